pipe_io_ports: RTL and testbench
================================

Name: pipe_io_ports

Overview:
- Parametrised memory-mapped I/O block for the MEM stage of the pipelined CPU.
- Generalises the fixed two-input / four-output port logic to NUM_IN inputs and NUM_OUT outputs.
- Adds: 2-flop input synchronisers, sticky change-detect status (clear-on-read), output readback, config word.
- Sits beside data RAM; the MEM stage muxes io_rdata over RAM data when io_hit=1.

Parameters:
- NUM_IN, 2, input channels (1..8)
- NUM_OUT, 4, output channels (1..8)
- IN_W, 6, width of each input pin group (1..32), zero-extended to 32 on read
- IO_BASE, 32'h0000_0080, base of 128-byte I/O window; bits [6:0] must be 0

Ports:
- clock  in  1  rising-edge clock (top connects the memory clock)
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from EXE/MEM register
- we  in  1  store strobe (mwmem)
- re  in  1  load strobe
- wdata  in  32  store data (mb)
- in_port  in  NUM_IN*IN_W  asynchronous external inputs; channel i at [i*IN_W +: IN_W]
- out_port  out  NUM_OUT*32  registered outputs; channel j at [j*32 +: 32]
- io_hit  out  1  combinational: addr[31:7]==IO_BASE[31:7]
- io_rdata  out  32  registered read data
- chg_irq  out  1  registered OR of all status bits

Behaviour:
- Offset map: off = addr[6:0]; only word-aligned accesses decode (addr[1:0] ignored).
  - 0x00+4i: input i, read-only, returns {zero, sync2[i]}, valid for i<NUM_IN
  - 0x20+4j: output j, read/write, valid for j<NUM_OUT
  - 0x40: STATUS, bit i = change flag of input i, upper bits 0; read clears
  - 0x44: CONFIG, read-only = {16'h0, 8'(NUM_OUT), 8'(NUM_IN)}
- Unmapped offsets inside the window: reads return 0; writes are ignored.
- Accesses outside the window are ignored; io_hit=0.
- Reset (async assert, released on the clock): out_port, io_rdata, sync1/sync2, STATUS and chg_irq all 0.
- Write: on the edge with we && io_hit && valid output offset, out_port[j] <= wdata. Visible on out_port and via readback from that edge.
- Read:
  - on the edge with re && io_hit, io_rdata <= selected value; 1-cycle latency.
  - when re is 0 or io_hit is 0, io_rdata <= 0.
- we and re both high: both act; readback returns the old out_port value.
- Input synchroniser, per channel:
  - sync1 <= in_port at edge t; sync2 <= sync1 at edge t+1.
  - Change flag set at edge t+1 when sync1 != sync2 before that edge. Edge t+1 is also the first edge at which the new value is readable.
  - A pulse shorter than one clock may be missed; this is acceptable.
- STATUS clear-on-read: a read of 0x40 captures STATUS into io_rdata and clears it on the same edge. A change flagged on that same edge stays set (set wins over clear).
- Repeated changes before a read leave the bit at 1; no counting.
- chg_irq <= |STATUS_next, so it updates on the same edge as STATUS.
- Reset asserted mid-access: the access is abandoned, all state is 0 immediately, and no partial write occurs.

Decomposition:
- Package pipe_io_pkg holds:
  - OFF_IN=7'h00, OFF_OUT=7'h20, OFF_STATUS=7'h40, OFF_CONFIG=7'h44
  - window mask 32'hFFFF_FF80
- One sub-module, io_sync_chan (parameter W).
  - Contains the 2-flop synchroniser plus the change-flag flop with set/clear inputs.
  - Instantiated NUM_IN times by generate.

Test Plan:
1. Reset: assert reset mid-cycle -> out_port=0, io_rdata=0, chg_irq=0 immediately. Read 0x80+0x44 after release -> 32'h0000_0402.
2. Write and readback: we=1, addr=0x000000A4, wdata=32'hDEAD_BEEF -> out_port[1]=DEAD_BEEF after one edge, other outputs 0. Read same address -> io_rdata=DEAD_BEEF one cycle later.
3. Input sync: in_port channel 0 changes 0->6'h2A before edge t -> read 0x80 returns 0 until edge t+1, then 32'h2A. STATUS=32'h1 and chg_irq=1 from edge t+1.
4. Clear-on-read collision: read 0xC0 on the same edge that channel 1 change is flagged -> io_rdata=32'h1. STATUS afterwards=32'h2 and chg_irq stays 1. A second read -> io_rdata=32'h2, STATUS=0, chg_irq=0.
5. Decode misses:
   - write to 0x00000100 -> io_hit=0, outputs unchanged.
   - write to 0x000000B8 (j=6 >= NUM_OUT) -> ignored; read returns 0.
   - read 0x84 with NUM_IN=1 -> 0.
6. Simultaneous we/re on 0xA0 with old value 5, wdata 9 -> io_rdata=5, out_port[0]=9.

Source files
------------

// File: rtl/pipe_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_io_pkg
// Description : Shared offsets, window mask and offset decoder for the
//               memory-mapped I/O block of the pipelined CPU MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_io_pkg;

  // Register offsets inside the 128-byte I/O window
  localparam logic [6:0]  OFF_IN     = 7'h00;
  localparam logic [6:0]  OFF_OUT    = 7'h20;
  localparam logic [6:0]  OFF_STATUS = 7'h40;
  localparam logic [6:0]  OFF_CONFIG = 7'h44;

  // Bits of the byte address that select the window itself
  localparam logic [31:0] WIN_MASK   = 32'hFFFF_FF80;

  // Register group selected by a word offset
  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_IN     = 3'd1,
    SEL_OUT    = 3'd2,
    SEL_STATUS = 3'd3,
    SEL_CONFIG = 3'd4
  } io_sel_e;

  // Classify a word offset (byte offset bits [6:2]). Input and output groups
  // occupy 8 words each; STATUS and CONFIG are single words.
  function automatic io_sel_e decode_word(input logic [4:0] word);
    io_sel_e sel;
    sel = SEL_NONE;
    if (word[4:3] == OFF_IN[6:5]) begin
      sel = SEL_IN;
    end else if (word[4:3] == OFF_OUT[6:5]) begin
      sel = SEL_OUT;
    end else if (word == OFF_STATUS[6:2]) begin
      sel = SEL_STATUS;
    end else if (word == OFF_CONFIG[6:2]) begin
      sel = SEL_CONFIG;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync_chan.sv
`default_nettype none
// ============================================================================
// Module      : io_sync_chan
// Description : One input channel: 2-flop synchroniser for an asynchronous
//               pin group plus a sticky change flag with set/clear.
// Revision    : 1.0 - initial release
// ============================================================================
module io_sync_chan #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         flag,
  output logic         flag_next
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  // A difference between the two stages means a new value lands in sync2 on
  // this edge; that sets the flag and takes priority over a clear-on-read.
  assign flag_next = (sync1 != sync2) | (flag & ~clr);
  assign dout      = sync2;

  // Synchroniser stages and sticky change flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      flag  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      flag  <= flag_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_io_ports.sv
`default_nettype none
// ============================================================================
// Module      : pipe_io_ports
// Description : Parametrised memory-mapped I/O ports beside data RAM:
//               synchronised inputs with sticky change status, registered
//               outputs with readback, and a read-only config word.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_io_ports
  import pipe_io_pkg::*;
#(
  parameter int          NUM_IN  = 2,
  parameter int          NUM_OUT = 4,
  parameter int          IN_W    = 6,
  parameter logic [31:0] IO_BASE = 32'h0000_0080
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [31:0]            wdata,
  input  logic [NUM_IN*IN_W-1:0] in_port,
  output logic [NUM_OUT*32-1:0]  out_port,
  output logic                   io_hit,
  output logic [31:0]            io_rdata,
  output logic                   chg_irq
);

  localparam logic [31:0] BASE_MASKED = IO_BASE & WIN_MASK;
  localparam logic [31:0] CONFIG_WORD = {16'h0000, 8'(NUM_OUT), 8'(NUM_IN)};

  io_sel_e            sel;
  logic [2:0]         chan;
  logic               wr_out;
  logic               rd_status;
  logic [31:0]        rd_next;
  logic [31:0]        in_word  [NUM_IN];
  logic [31:0]        out_reg  [NUM_OUT];
  logic [NUM_IN-1:0]  flags;
  logic [NUM_IN-1:0]  flags_next;
  logic               unused_byte_lane;

  // Byte-lane bits do not take part in decode; all accesses are word-wide.
  assign unused_byte_lane = ^addr[1:0];

  assign io_hit    = ((addr & WIN_MASK) == BASE_MASKED);
  assign sel       = decode_word(addr[6:2]);
  assign chan      = addr[4:2];
  assign wr_out    = we & io_hit & (sel == SEL_OUT);
  assign rd_status = re & io_hit & (sel == SEL_STATUS);

  // Input channels: synchroniser + change flag each
  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
      logic [IN_W-1:0] sync_val;

      io_sync_chan #(
        .W (IN_W)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .din       (in_port[i*IN_W +: IN_W]),
        .clr       (rd_status),
        .dout      (sync_val),
        .flag      (flags[i]),
        .flag_next (flags_next[i])
      );

      assign in_word[i] = 32'(sync_val);
    end
  endgenerate

  // Output channels: a write to an unimplemented channel matches no register
  generate
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      // Output register j, loaded by a decoded store
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          out_reg[j] <= '0;
        end else if (wr_out && (chan == 3'(j))) begin
          out_reg[j] <= wdata;
        end
      end

      assign out_port[j*32 +: 32] = out_reg[j];
    end
  endgenerate

  // Read-data select; unmapped or non-read cycles yield zero. Output readback
  // uses the pre-edge register so a concurrent store returns the old value.
  always_comb begin
    rd_next = '0;
    if (re && io_hit) begin
      case (sel)
        SEL_IN: begin
          for (int i = 0; i < NUM_IN; i++) begin
            if (chan == 3'(i)) rd_next = in_word[i];
          end
        end
        SEL_OUT: begin
          for (int j = 0; j < NUM_OUT; j++) begin
            if (chan == 3'(j)) rd_next = out_reg[j];
          end
        end
        SEL_STATUS: rd_next = 32'(flags);
        SEL_CONFIG: rd_next = CONFIG_WORD;
        default:    rd_next = '0;
      endcase
    end
  end

  // Registered read data and interrupt, tracking the next status value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_rdata <= '0;
      chg_irq  <= 1'b0;
    end else begin
      io_rdata <= rd_next;
      chg_irq  <= |flags_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_io_ports.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_io_ports
// Description : Scoreboard bench for pipe_io_ports. Reads push expected data;
//               a monitor pops and compares one edge later. A second instance
//               with NUM_IN=1 covers the single-input decode case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_io_ports;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    bit          c1;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [31:0]  addr;
  logic         we;
  logic         re;
  logic [31:0]  wdata;
  logic [11:0]  in_port;
  logic [127:0] out_port;
  logic         io_hit;
  logic [31:0]  io_rdata;
  logic         chg_irq;
  logic [127:0] out_port1;
  logic         io_hit1;
  logic [31:0]  io_rdata1;
  logic         chg_irq1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_io_ports dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .re       (re),
    .wdata    (wdata),
    .in_port  (in_port),
    .out_port (out_port),
    .io_hit   (io_hit),
    .io_rdata (io_rdata),
    .chg_irq  (chg_irq)
  );

  pipe_io_ports #(.NUM_IN(1)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .re       (re),
    .wdata    (wdata),
    .in_port  (in_port[5:0]),
    .out_port (out_port1),
    .io_hit   (io_hit1),
    .io_rdata (io_rdata1),
    .chg_irq  (chg_irq1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Store: called at a falling edge, completes at the next falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clock);
    we    = 1'b0;
  endtask

  // Load: expected data for both instances goes to the scoreboard
  task automatic rd(input logic [31:0] a, input logic [31:0] e0,
                    input logic [31:0] e1, input bit c1);
    exp_t e;
    e.e0 = e0;
    e.e1 = e1;
    e.c1 = c1;
    addr = a;
    re   = 1'b1;
    q.push_back(e);
    @(negedge clock);
    re   = 1'b0;
  endtask

  // Monitor: a read seen at an edge is checked 1 ns after it; otherwise
  // io_rdata must be zero.
  initial begin
    logic was_rd;
    exp_t e;
    forever begin
      @(posedge clock);
      was_rd = re;
      #1;
      if (was_rd) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got read with no expected entry");
        end else begin
          e = q.pop_front();
          chk("rdata", {96'h0, io_rdata}, {96'h0, e.e0});
          if (e.c1) chk("rdata_n1", {96'h0, io_rdata1}, {96'h0, e.e1});
        end
      end else begin
        chk("rdata_idle", {96'h0, io_rdata}, 128'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    addr    = '0;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = '0;
    in_port = '0;
    @(negedge clock);
    chk("rst_out", out_port, 128'h0);
    chk("rst_irq", {127'h0, chg_irq}, 128'h0);
    @(negedge clock);
    reset = 1'b0;

    // 1. Mid-cycle reset clears outputs, read data and interrupt at once
    wr(32'h0000_00A0, 32'h0000_1234);
    in_port = 12'h001;
    repeat (3) @(negedge clock);
    chk("irq_pre_rst", {127'h0, chg_irq}, 128'h1);
    rd(32'h0000_00A0, 32'h0000_1234, 32'h0000_1234, 1'b1);
    #2;
    reset   = 1'b1;
    in_port = '0;
    #1;
    chk("rst_mid_out", out_port, 128'h0);
    chk("rst_mid_rdata", {96'h0, io_rdata}, 128'h0);
    chk("rst_mid_irq", {127'h0, chg_irq}, 128'h0);
    @(negedge clock);
    reset = 1'b0;
    rd(32'h0000_00C4, 32'h0000_0402, 32'h0000_0401, 1'b1);

    // 2. Write and readback
    wr(32'h0000_00A4, 32'hDEAD_BEEF);
    chk("wr_out1", out_port, {64'h0, 32'hDEAD_BEEF, 32'h0});
    chk("hit_a4", {127'h0, io_hit}, 128'h1);
    rd(32'h0000_00A4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    // 3. Input synchroniser latency and change flag
    in_port = 12'h02A;
    rd(32'h0000_0080, 32'h0, 32'h0, 1'b1);
    chk("irq_edge_t", {127'h0, chg_irq}, 128'h0);
    @(negedge clock);
    chk("irq_edge_t1", {127'h0, chg_irq}, 128'h1);
    rd(32'h0000_0080, 32'h0000_002A, 32'h0000_002A, 1'b1);

    // 4. Clear-on-read colliding with a new change on channel 1
    in_port = {6'h15, 6'h2A};
    @(negedge clock);
    rd(32'h0000_00C0, 32'h1, 32'h1, 1'b1);
    chk("irq_after_rd1", {127'h0, chg_irq}, 128'h1);
    rd(32'h0000_00C0, 32'h2, 32'h0, 1'b1);
    chk("irq_after_rd2", {127'h0, chg_irq}, 128'h0);
    rd(32'h0000_00C0, 32'h0, 32'h0, 1'b1);

    // 5. Decode misses
    wr(32'h0000_0100, 32'hFFFF_FFFF);
    chk("hit_out_win", {127'h0, io_hit}, 128'h0);
    chk("out_unchg1", out_port, {64'h0, 32'hDEAD_BEEF, 32'h0});
    wr(32'h0000_00B8, 32'h0000_0055);
    chk("out_unchg2", out_port, {64'h0, 32'hDEAD_BEEF, 32'h0});
    rd(32'h0000_00B8, 32'h0, 32'h0, 1'b1);
    rd(32'h0000_0088, 32'h0, 32'h0, 1'b1);
    rd(32'h0000_0084, 32'h0000_0015, 32'h0, 1'b1);
    rd(32'h0000_00C8, 32'h0, 32'h0, 1'b1);
    rd(32'h0000_0104, 32'h0, 32'h0, 1'b1);

    // 6. Simultaneous store and load return the old value
    wr(32'h0000_00A0, 32'h0000_0005);
    begin
      exp_t e;
      e.e0  = 32'h5;
      e.e1  = 32'h5;
      e.c1  = 1'b1;
      addr  = 32'h0000_00A0;
      wdata = 32'h0000_0009;
      we    = 1'b1;
      re    = 1'b1;
      q.push_back(e);
      @(negedge clock);
      we    = 1'b0;
      re    = 1'b0;
    end
    chk("wr_rd_out0", out_port, {64'h0, 32'hDEAD_BEEF, 32'h9});
    rd(32'h0000_00A0, 32'h9, 32'h9, 1'b1);

    repeat (3) @(negedge clock);
    chk("sb_drained", 128'(q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
